// File: rtl/md_unit_pkg.sv
// ============================================================================
// Module : md_unit_pkg
// Brief  : Shared md_op encodings and HI/LO sequencer states for md_unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package md_unit_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8,
        MD_MADD  = 4'd9,
        MD_MADDU = 4'd10,
        MD_MSUB  = 4'd11,
        MD_MSUBU = 4'd12
    } md_op_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

endpackage

`default_nettype wire

// File: rtl/md_unit_if.sv
// ============================================================================
// Module : md_unit_if
// Brief  : E-stage request/response bundle between pipeline and md_unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface md_unit_if;
    logic        req;
    logic [3:0]  md_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        start;
    logic        busy;
    logic [31:0] hilo_out;

    modport master (output req, md_op, rs_data, rt_data,
                    input  start, busy, hilo_out);
    modport slave  (input  req, md_op, rs_data, rt_data,
                    output start, busy, hilo_out);
endinterface

`default_nettype wire

// File: rtl/md_counter.sv
// ============================================================================
// Module : md_counter
// Brief  : Load/decrement down-counter; busy while non-zero, done on last cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module md_counter #(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_val,
    output logic                  busy,
    output logic                  done
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign busy = (count_q != '0);
    assign done = (count_q == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/md_unit.sv
// ============================================================================
// Module : md_unit
// Brief  : Multi-cycle multiply/divide with HI/LO registers (MIPS E stage).
//          Define MD_MADD_EN to add madd/maddu/msub/msubu accumulate ops.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input wire logic  clk,
    input wire logic  reset,
    md_unit_if.slave  bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e    state_q, state_d;
    logic [31:0]  hi_q, hi_d;
    logic [31:0]  lo_q, lo_d;
    logic [63:0]  pend_q, pend_d;
    logic         pend_we_q, pend_we_d;

    logic [31:0]  a, b;
    logic signed [63:0] prod_s;
    logic [63:0]  prod_u;
    logic [31:0]  quot, rem;
    logic [63:0]  pend_calc;
    logic         pend_we_calc;
    logic         op_start, op_div, start_go;
    logic         cnt_busy, cnt_done;
    logic [CNT_W-1:0] cnt_load;

    assign a = bus.rs_data;
    assign b = bus.rt_data;

    always_comb begin
        prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u = {32'd0, a} * {32'd0, b};
        quot   = '0;
        rem    = '0;
        // Divisor zero is never evaluated; the op still runs but skips commit.
        if (b != 32'd0) begin
            if (bus.md_op == MD_DIVU) begin
                quot = a / b;
                rem  = a % b;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                quot = 32'h8000_0000;
                rem  = 32'd0;
            end else begin
                quot = $signed(a) / $signed(b);
                rem  = $signed(a) % $signed(b);
            end
        end
    end

    always_comb begin
        op_start     = 1'b0;
        op_div       = 1'b0;
        pend_calc    = '0;
        pend_we_calc = 1'b1;
        case (bus.md_op)
            MD_MULT:  begin op_start = 1'b1; pend_calc = prod_s; end
            MD_MULTU: begin op_start = 1'b1; pend_calc = prod_u; end
            MD_DIV, MD_DIVU: begin
                op_start     = 1'b1;
                op_div       = 1'b1;
                pend_calc    = {rem, quot};
                pend_we_calc = (b != 32'd0);
            end
`ifdef MD_MADD_EN
            MD_MADD:  begin op_start = 1'b1; pend_calc = {hi_q, lo_q} + prod_s; end
            MD_MADDU: begin op_start = 1'b1; pend_calc = {hi_q, lo_q} + prod_u; end
            MD_MSUB:  begin op_start = 1'b1; pend_calc = {hi_q, lo_q} - prod_s; end
            MD_MSUBU: begin op_start = 1'b1; pend_calc = {hi_q, lo_q} - prod_u; end
`else
`endif
            default: ;
        endcase
    end

    assign bus.start = op_start && !bus.req;
    assign start_go  = bus.start && (state_q == ST_IDLE);
    assign cnt_load  = op_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

    md_counter #(.WIDTH(CNT_W)) u_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (start_go),
        .load_val (cnt_load),
        .busy     (cnt_busy),
        .done     (cnt_done)
    );

    assign bus.busy = cnt_busy;

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_d    = pend_q;
        pend_we_d = pend_we_q;
        case (state_q)
            ST_IDLE: begin
                if (start_go) begin
                    state_d   = ST_BUSY;
                    pend_d    = pend_calc;
                    pend_we_d = pend_we_calc;
                end
            end
            ST_BUSY: begin
                if (cnt_done) begin
                    state_d = ST_IDLE;
                    if (pend_we_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!bus.req && !cnt_busy) begin
            if (bus.md_op == MD_MTHI) hi_d = bus.rs_data;
            if (bus.md_op == MD_MTLO) lo_d = bus.rs_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_q    <= '0;
            pend_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_q    <= pend_d;
            pend_we_q <= pend_we_d;
        end
    end

    assign bus.hilo_out = (bus.md_op == MD_MFHI) ? hi_q :
                          (bus.md_op == MD_MFLO) ? lo_q : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// ============================================================================
// Module : tb_md_unit
// Brief  : Directed self-checking bench for md_unit (HI/LO mult/div unit).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_md_unit;
    import md_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc;
    logic [31:0] hi, lo;

    always #5 clk = ~clk;

    md_unit_if bus ();

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] ra, input logic [31:0] rb);
        bus.md_op   = op;
        bus.rs_data = ra;
        bus.rt_data = rb;
        #1;
    endtask

    task automatic read_hl(output logic [31:0] rhi, output logic [31:0] rlo);
        bus.md_op = MD_MFHI;
        #1 rhi = bus.hilo_out;
        bus.md_op = MD_MFLO;
        #1 rlo = bus.hilo_out;
        bus.md_op = MD_NONE;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 64) begin
            n++;
            tick();
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] ra, input logic [31:0] rb,
                          output int n);
        drive(op, ra, rb);
        tick();
        bus.md_op = MD_NONE;
        wait_idle(n);
    endtask

    // A new md op must never be issued while one is in flight.
    always @(negedge clk) begin
        if (bus.busy === 1'b1) begin
            n_cmp++;
            assert (bus.start === 1'b0) else begin
                n_bad++;
                $error("FAIL start_while_busy: observed %0b expected 0", bus.start);
            end
        end
    end

    initial begin
        reset       = 1'b1;
        bus.req     = 1'b0;
        bus.md_op   = MD_NONE;
        bus.rs_data = '0;
        bus.rt_data = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("reset_busy", bus.busy, 32'd0);
        chk("reset_start", bus.start, 32'd0);
        read_hl(hi, lo);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);

        tick();
        drive(MD_MULT, 32'hFFFF_FFFF, 32'd2);
        chk("mult_start", bus.start, 32'd1);
        tick();
        bus.md_op = MD_NONE;
        wait_idle(cyc);
        chk("mult_cycles", cyc, 32'd5);
        read_hl(hi, lo);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFE);

        tick();
        drive(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
        tick();
        bus.md_op = MD_MFLO;
        #1;
        chk("mflo_during_busy", bus.hilo_out, 32'hFFFF_FFFE);
        chk("multu_busy", bus.busy, 32'd1);
        bus.md_op = MD_NONE;
        wait_idle(cyc);
        chk("multu_cycles", cyc, 32'd5);
        read_hl(hi, lo);
        chk("multu_hi", hi, 32'd1);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        tick();
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, cyc);
        chk("div_cycles", cyc, 32'd10);
        read_hl(hi, lo);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        chk("div_lo", lo, 32'hFFFF_FFFD);

        tick();
        run_op(MD_DIVU, 32'd7, 32'd0, cyc);
        chk("divu0_cycles", cyc, 32'd10);
        read_hl(hi, lo);
        chk("divu0_hi", hi, 32'hFFFF_FFFF);
        chk("divu0_lo", lo, 32'hFFFF_FFFD);

        tick();
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        read_hl(hi, lo);
        chk("divovf_hi", hi, 32'd0);
        chk("divovf_lo", lo, 32'h8000_0000);

        tick();
        run_op(MD_DIVU, 32'd100, 32'd7, cyc);
        read_hl(hi, lo);
        chk("divu_hi", hi, 32'd2);
        chk("divu_lo", lo, 32'd14);

        tick();
        drive(MD_MTHI, 32'h0000_1234, 32'd0);
        tick();
        bus.md_op = MD_MFHI;
        #1;
        chk("mthi_mfhi", bus.hilo_out, 32'h0000_1234);
        drive(MD_MTLO, 32'h0000_5678, 32'd0);
        tick();
        read_hl(hi, lo);
        chk("mtlo_hi", hi, 32'h0000_1234);
        chk("mtlo_lo", lo, 32'h0000_5678);

        tick();
        bus.req = 1'b1;
        drive(MD_MULT, 32'd3, 32'd3);
        chk("req_start", bus.start, 32'd0);
        tick();
        chk("req_busy", bus.busy, 32'd0);
        drive(MD_MTHI, 32'h0000_BEEF, 32'd0);
        tick();
        bus.req = 1'b0;
        read_hl(hi, lo);
        chk("req_hi", hi, 32'h0000_1234);
        chk("req_lo", lo, 32'h0000_5678);

        tick();
        drive(MD_MULTU, 32'h0001_0000, 32'h0003_0004);
        tick();
        bus.md_op = MD_NONE;
        tick();
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        wait_idle(cyc);
        read_hl(hi, lo);
        chk("reqmid_hi", hi, 32'd3);
        chk("reqmid_lo", lo, 32'h0004_0000);

        tick();
        drive(MD_DIV, 32'd100, 32'd7);
        tick();
        bus.md_op = MD_NONE;
        tick();
        tick();
        chk("rst_mid_busy_before", bus.busy, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_busy", bus.busy, 32'd0);
        read_hl(hi, lo);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        repeat (12) tick();
        read_hl(hi, lo);
        chk("rst_late_hi", hi, 32'd0);
        chk("rst_late_lo", lo, 32'd0);

        tick();
        drive(MD_MTLO, 32'hFFFF_FFFF, 32'd0);
        tick();
        drive(MD_MADDU, 32'd1, 32'd1);
`ifdef MD_MADD_EN
        chk("maddu_start", bus.start, 32'd1);
`else
        chk("maddu_start", bus.start, 32'd0);
`endif
        tick();
        bus.md_op = MD_NONE;
        wait_idle(cyc);
        read_hl(hi, lo);
`ifdef MD_MADD_EN
        chk("maddu_cycles", cyc, 32'd5);
        chk("maddu_hi", hi, 32'd1);
        chk("maddu_lo", lo, 32'd0);
`else
        chk("maddu_cycles", cyc, 32'd0);
        chk("maddu_hi", hi, 32'd0);
        chk("maddu_lo", lo, 32'hFFFF_FFFF);
`endif

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
